// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end: fetch granularity, default
// instruction memory size and the word-alignment mask.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES       = 4;
  localparam int unsigned DEFAULT_MEM_BYTES = 512;
  localparam logic [1:0]  ALIGN_MASK        = 2'b11;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational fetch-address select (redirect > stall replay > sequential PC)
// plus the legality check and the PC that follows the selected address.
module pc_next_mux
  import mips_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic        redirect,
  input  logic        stall,
  input  logic        fetchFault,
  input  logic [31:0] redirectTarget,
  input  logic [31:0] reqPC,
  input  logic [31:0] pcReg,
  output logic [31:0] memAddress,
  output logic [31:0] nextPC,
  output logic        fetchOk
);

  logic        aligned;
  logic        inRange;
  logic [32:0] lastByte;

  always_comb begin
    memAddress = pcReg;
    if (redirect) begin
      memAddress = redirectTarget;
    end else if (stall) begin
      memAddress = reqPC;
    end
  end

  // Both the redirect and the sequential case advance from the selected address.
  assign nextPC   = memAddress + 32'(INSTR_BYTES);

  // Widened so an address near 2^32 cannot wrap past the range check.
  assign lastByte = {1'b0, memAddress} + 33'd3;
  assign aligned  = (memAddress[1:0] & ALIGN_MASK) == 2'b00;
  assign inRange  = lastByte < 33'(MEM_BYTES);
  assign fetchOk  = aligned && inRange && !fetchFault;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, hides the instruction memory's one-cycle read
// latency and feeds decode through the IF/ID register.
module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] memAddress,
  input  logic [31:0] memInstruction,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic [31:0] ifidInstruction,
  output logic [31:0] ifidPC,
  output logic [31:0] ifidPCPlus4,
  output logic        ifidValid,
  output logic        fetchFault,
  output logic [31:0] faultAddress,
  output logic [31:0] fetchCount
);

  logic [31:0] pcReg;
  logic [31:0] reqPC;
  logic        reqValid;
  logic [31:0] nextPC;
  logic        fetchOk;

  pc_next_mux #(
    .MEM_BYTES(MEM_BYTES)
  ) u_pc_next_mux (
    .redirect      (redirect),
    .stall         (stall),
    .fetchFault    (fetchFault),
    .redirectTarget(redirectTarget),
    .reqPC         (reqPC),
    .pcReg         (pcReg),
    .memAddress    (memAddress),
    .nextPC        (nextPC),
    .fetchOk       (fetchOk)
  );

  // Request stage (pcReg/reqPC) and IF/ID stage advance together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcReg           <= RESET_PC;
      reqPC           <= 32'h0;
      reqValid        <= 1'b0;
      ifidInstruction <= NOP_INSTR;
      ifidPC          <= 32'h0;
      ifidPCPlus4     <= 32'h0;
      ifidValid       <= 1'b0;
      fetchFault      <= 1'b0;
      faultAddress    <= 32'h0;
      fetchCount      <= 32'h0;
    end else if (fetchFault) begin
      reqValid  <= 1'b0;
      ifidValid <= 1'b0;
    end else if (redirect) begin
      ifidValid <= 1'b0;
      reqPC     <= redirectTarget;
      reqValid  <= fetchOk;
      pcReg     <= nextPC;
      if (!fetchOk) begin
        fetchFault   <= 1'b1;
        faultAddress <= redirectTarget;
      end
    end else if (!stall) begin
      ifidInstruction <= memInstruction;
      ifidPC          <= reqPC;
      ifidPCPlus4     <= reqPC + 32'(INSTR_BYTES);
      ifidValid       <= reqValid;
      reqPC           <= pcReg;
      reqValid        <= fetchOk;
      pcReg           <= nextPC;
      if (reqValid) begin
        fetchCount <= fetchCount + 32'd1;
      end
      if (!fetchOk) begin
        fetchFault   <= 1'b1;
        faultAddress <= pcReg;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized
// stall/redirect traffic against a transaction-level reference model.
module tb_instruction_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] memAddress;
  logic [31:0] memInstruction;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] ifidInstruction;
  logic [31:0] ifidPC;
  logic [31:0] ifidPCPlus4;
  logic        ifidValid;
  logic        fetchFault;
  logic [31:0] faultAddress;
  logic [31:0] fetchCount;

  int nChecks = 0;
  int nErrors = 0;

  logic [31:0] mem [0:127];

  // Reference model state: what decode should see, in architectural terms.
  logic [31:0] m_nextPc, m_reqPc, m_ifPc, m_ifPc4, m_ifInstr, m_faultAddr, m_count;
  logic        m_reqV, m_ifV, m_ifKnown, m_fault;

  always #5 clock = ~clock;

  // Instruction memory: registered read, garbage outside the array.
  always @(posedge clock) begin
    if (memAddress < 32'd512) memInstruction <= mem[memAddress[8:2]];
    else                      memInstruction <= $urandom();
  end

  instruction_fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .memAddress     (memAddress),
    .memInstruction (memInstruction),
    .stall          (stall),
    .redirect       (redirect),
    .redirectTarget (redirectTarget),
    .ifidInstruction(ifidInstruction),
    .ifidPC         (ifidPC),
    .ifidPCPlus4    (ifidPCPlus4),
    .ifidValid      (ifidValid),
    .fetchFault     (fetchFault),
    .faultAddress   (faultAddress),
    .fetchCount     (fetchCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [31:0] addr);
    return (addr % 4 == 0) && (addr <= 32'd508);
  endfunction

  task automatic model_reset();
    m_nextPc = 0; m_reqPc = 0; m_reqV = 0;
    m_ifPc = 0; m_ifPc4 = 0; m_ifInstr = 0; m_ifV = 0; m_ifKnown = 1;
    m_fault = 0; m_faultAddr = 0; m_count = 0;
  endtask

  function automatic logic [31:0] model_addr(input logic st, input logic rd, input logic [31:0] tgt);
    if (rd) return tgt;
    if (st) return m_reqPc;
    return m_nextPc;
  endfunction

  task automatic model_edge(input logic st, input logic rd, input logic [31:0] tgt);
    logic ok;
    ok = legal(model_addr(st, rd, tgt)) && !m_fault;
    if (m_fault) begin
      m_reqV = 0;
      m_ifV  = 0;
    end else if (rd) begin
      m_ifV    = 0;
      m_reqPc  = tgt;
      m_reqV   = ok;
      m_nextPc = tgt + 4;
      if (!ok) begin m_fault = 1; m_faultAddr = tgt; end
    end else if (!st) begin
      if (m_reqV) begin
        m_count++;
        m_ifInstr = mem[m_reqPc / 4];
      end
      m_ifPc    = m_reqPc;
      m_ifPc4   = m_reqPc + 4;
      m_ifV     = m_reqV;
      m_ifKnown = m_reqV;
      m_reqPc   = m_nextPc;
      m_reqV    = ok;
      if (!ok) begin m_fault = 1; m_faultAddr = m_nextPc; end
      m_nextPc  = m_nextPc + 4;
    end
  endtask

  task automatic check_outputs();
    chk("ifidValid", ifidValid, m_ifV);
    chk("ifidPC", ifidPC, m_ifPc);
    chk("ifidPCPlus4", ifidPCPlus4, m_ifPc4);
    if (m_ifKnown) chk("ifidInstruction", ifidInstruction, m_ifInstr);
    chk("fetchFault", fetchFault, m_fault);
    chk("faultAddress", faultAddress, m_faultAddr);
    chk("fetchCount", fetchCount, m_count);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
    stall = st; redirect = rd; redirectTarget = tgt;
    #1;
    chk("memAddress", memAddress, model_addr(st, rd, tgt));
    model_edge(st, rd, tgt);
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  // Asynchronous reset between edges, checked before any clock edge occurs.
  task automatic do_reset();
    stall = 0; redirect = 0; redirectTarget = 0;
    #1 reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    chk("reset_memAddress", memAddress, 32'h0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [31:0] savedCount;
  logic [31:0] tgt;
  int          r;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom();
    mem[0] = 32'h2108_0008;
    mem[1] = 32'hAC08_0000;
    reset = 1'b1; stall = 0; redirect = 0; redirectTarget = 0;
    @(negedge clock);
    do_reset();

    // Startup: first instruction at the second edge.
    step(0, 0, 0);
    chk("edge1_valid", ifidValid, 1'b0);
    step(0, 0, 0);
    chk("edge2_instr", ifidInstruction, 32'h2108_0008);
    chk("edge2_pc", ifidPC, 32'h0);
    chk("edge2_pc4", ifidPCPlus4, 32'h4);
    chk("edge2_valid", ifidValid, 1'b1);

    // Stall with PC 4 in flight.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("stall_memAddress", memAddress, 32'h4);
      chk("stall_instr", ifidInstruction, 32'h2108_0008);
      chk("stall_pc", ifidPC, 32'h0);
    end
    step(0, 0, 0);
    chk("release_instr", ifidInstruction, 32'hAC08_0000);
    chk("release_pc", ifidPC, 32'h4);
    chk("release_count", fetchCount, 32'd2);
    step(0, 0, 0);

    // Redirect squashes, target arrives on the following edge.
    step(0, 1, 32'h20);
    chk("redir_squash", ifidValid, 1'b0);
    step(0, 0, 0);
    chk("redir_pc", ifidPC, 32'h20);
    chk("redir_pc4", ifidPCPlus4, 32'h24);
    chk("redir_valid", ifidValid, 1'b1);

    // Redirect beats stall.
    step(1, 1, 32'h10);
    chk("redirstall_squash", ifidValid, 1'b0);
    step(0, 0, 0);
    chk("redirstall_pc", ifidPC, 32'h10);

    // Run off the end of memory.
    step(0, 1, 32'h1F8);
    step(0, 0, 0);
    chk("end_pc1f8", ifidPC, 32'h1F8);
    step(0, 0, 0);
    chk("end_pc1fc", ifidPC, 32'h1FC);
    chk("end_valid", ifidValid, 1'b1);
    chk("end_fault", fetchFault, 1'b1);
    chk("end_faultAddr", faultAddress, 32'h200);
    savedCount = fetchCount;
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("end_after_valid", ifidValid, 1'b0);
    chk("end_count_frozen", fetchCount, savedCount);

    // Mid-stream async reset, then a misaligned redirect.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    do_reset();
    chk("rst_mid_valid", ifidValid, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    savedCount = fetchCount;
    step(0, 1, 32'h22);
    chk("mis_fault", fetchFault, 1'b1);
    chk("mis_faultAddr", faultAddress, 32'h22);
    chk("mis_valid", ifidValid, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("mis_valid_later", ifidValid, 1'b0);
    chk("mis_count_frozen", fetchCount, savedCount);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 75 == 74) do_reset();
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) tgt = 32'($urandom_range(0, 600));
      else                            tgt = 32'($urandom_range(0, 127)) << 2;
      step(r < 25, r >= 88, tgt);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
